// File: rtl/alu_ccr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_ccr_ctrl
// Description : Condition-code register controller for the EX-stage ALU.
//               Commits ALU flags into the CCR under a per-function update
//               mask, applies SETC/CLRC and conditional-jump flag consumption,
//               and keeps a small CCR save stack for interrupt entry / RTI.
//               CCR layout: bit0 = Z, bit1 = N, bit2 = C.
// Ports       : clk, rst (async, active-high)
//               alu_valid/alu_func/alu_flags : committing ALU op and its flags
//               setc/clrc                    : carry set / clear instructions
//               jmp_cond/jmp_taken           : conditional jump flag consume
//               save/restore                 : CCR push (IRQ entry) / pop (RTI)
//               ccr                          : registered architectural CCR
//               stack_full/stack_empty       : registered stack occupancy
//               stack_err                    : sticky overflow/underflow/conflict
//               ccr_fwd (CCR_FWD_EN only)    : combinational next CCR value
// Options     : define CCR_FWD_EN to add the ccr_fwd forwarding output.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ccr_ctrl #(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [3:0]        alu_func,
    input  logic [15:0]       alu_flags,
    input  logic              setc,
    input  logic              clrc,
    input  logic [1:0]        jmp_cond,
    input  logic              jmp_taken,
    input  logic              save,
    input  logic              restore,
    output logic [FLAG_W-1:0] ccr,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
`ifdef CCR_FWD_EN
    ,
    output logic [FLAG_W-1:0] ccr_fwd
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam int C_BIT_Z = 0;
    localparam int C_BIT_N = 1;
    localparam int C_BIT_C = 2;

    logic [FLAG_W-1:0] r_ccr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_err;
    logic [FLAG_W-1:0] r_stack [DEPTH];

    logic [FLAG_W-1:0] w_ccr_jmp;
    logic [FLAG_W-1:0] w_ccr_sc;
    logic [FLAG_W-1:0] w_mask;
    logic [FLAG_W-1:0] w_ccr_alu;
    logic [FLAG_W-1:0] w_ccr_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [AW-1:0]     w_top_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_err_ev;
    logic              w_unused;

    // Only the low FLAG_W ALU flag bits are architectural.
    assign w_unused = ^alu_flags[15:FLAG_W];

    // Which CCR bits a committing ALU function is allowed to write.
    function automatic logic [FLAG_W-1:0] f_mask(input logic [3:0] func);
        logic [FLAG_W-1:0] m;
        m = '0;
        case (func)
            4'b0101, 4'b1010, 4'b1011: begin
                m[C_BIT_Z] = 1'b1;
                m[C_BIT_N] = 1'b1;
            end
            4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1100, 4'b1101: begin
                m[C_BIT_Z] = 1'b1;
                m[C_BIT_N] = 1'b1;
                m[C_BIT_C] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Save and restore in the same cycle cancel each other and flag an error.
    assign w_push   = save && !restore && (r_count != C_DEPTH);
    assign w_pop    = restore && !save && (r_count != '0);
    assign w_err_ev = (save && restore)
                   || (save && !restore && (r_count == C_DEPTH))
                   || (restore && !save && (r_count == '0));

    // Lower AW bits wrap naturally: count==DEPTH gives index DEPTH-1.
    assign w_top_idx = r_count[AW-1:0] - AW'(1);

    // Priority chain: jump clear < setc/clrc < ALU update < stack pop.
    always_comb begin
        w_ccr_jmp = r_ccr;
        if (jmp_taken) begin
            case (jmp_cond)
                2'b01:   w_ccr_jmp[C_BIT_Z] = 1'b0;
                2'b10:   w_ccr_jmp[C_BIT_N] = 1'b0;
                2'b11:   w_ccr_jmp[C_BIT_C] = 1'b0;
                default: w_ccr_jmp = r_ccr;
            endcase
        end

        w_ccr_sc = w_ccr_jmp;
        if (setc && !clrc) begin
            w_ccr_sc[C_BIT_C] = 1'b1;
        end else if (clrc && !setc) begin
            w_ccr_sc[C_BIT_C] = 1'b0;
        end

        w_mask    = alu_valid ? f_mask(alu_func) : '0;
        w_ccr_alu = (w_ccr_sc & ~w_mask) | (alu_flags[FLAG_W-1:0] & w_mask);

        w_ccr_nxt = w_pop ? r_stack[w_top_idx] : w_ccr_alu;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ccr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_ccr   <= w_ccr_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= (w_count_nxt == '0);
            r_err   <= r_err | w_err_ev;
        end
    end

    // Stack storage needs no reset; occupancy is tracked by r_count.
    // The pushed value is the pre-update CCR.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_count[AW-1:0]] <= r_ccr;
        end
    end

    assign ccr         = r_ccr;
    assign stack_full  = r_full;
    assign stack_empty = r_empty;
    assign stack_err   = r_err;

`ifdef CCR_FWD_EN
    assign ccr_fwd = w_ccr_nxt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ccr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ccr_ctrl
// Description : Self-checking bench for alu_ccr_ctrl. A vector table holds
//               stimulus plus hand-derived expected CCR/stack outputs; the
//               expectation is queued when a vector is driven and popped when
//               the registered outputs are sampled after the clock edge.
//               Asynchronous reset is checked between clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ccr_ctrl;

    localparam int FLAG_W = 3;
    localparam logic [3:0] F_NOP  = 4'b0000;
    localparam logic [3:0] F_UNU  = 4'b0001;
    localparam logic [3:0] F_MOV1 = 4'b0011;
    localparam logic [3:0] F_NOT  = 4'b0101;
    localparam logic [3:0] F_INC  = 4'b0110;
    localparam logic [3:0] F_ADD  = 4'b1000;
    localparam logic [3:0] F_SUB  = 4'b1001;
    localparam logic [3:0] F_AND  = 4'b1010;
    localparam logic [3:0] F_OR   = 4'b1011;

    typedef struct packed {
        logic        do_rst;
        logic        valid;
        logic [3:0]  func;
        logic [15:0] flags;
        logic        setc;
        logic        clrc;
        logic [1:0]  jc;
        logic        jt;
        logic        save;
        logic        restore;
        logic [2:0]  e_ccr;
        logic        e_full;
        logic        e_empty;
        logic        e_err;
    } vec_t;

    typedef struct packed {
        logic [2:0] ccr;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic [3:0]        alu_func;
    logic [15:0]       alu_flags;
    logic              setc;
    logic              clrc;
    logic [1:0]        jmp_cond;
    logic              jmp_taken;
    logic              save;
    logic              restore;
    logic [FLAG_W-1:0] ccr;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;
`ifdef CCR_FWD_EN
    logic [FLAG_W-1:0] ccr_fwd;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[31];

    alu_ccr_ctrl #(.DEPTH(4), .FLAG_W(FLAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_func    (alu_func),
        .alu_flags   (alu_flags),
        .setc        (setc),
        .clrc        (clrc),
        .jmp_cond    (jmp_cond),
        .jmp_taken   (jmp_taken),
        .save        (save),
        .restore     (restore),
        .ccr         (ccr),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
`ifdef CCR_FWD_EN
        ,
        .ccr_fwd     (ccr_fwd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] f,
                                input logic [15:0] fl, input logic sc, input logic cc,
                                input logic [1:0] jc, input logic jt, input logic sv,
                                input logic rs, input logic [2:0] ec, input logic ef,
                                input logic ee, input logic er);
        vec_t t;
        t.do_rst = r;  t.valid = v;  t.func = f;   t.flags = fl;
        t.setc = sc;   t.clrc = cc;  t.jc = jc;    t.jt = jt;
        t.save = sv;   t.restore = rs;
        t.e_ccr = ec;  t.e_full = ef; t.e_empty = ee; t.e_err = er;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] act,
                         input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %b required %b", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_func = F_NOP; alu_flags = 16'h0000;
        setc = 1'b0; clrc = 1'b0; jmp_cond = 2'b00; jmp_taken = 1'b0;
        save = 1'b0; restore = 1'b0;
    endtask

    // Pulse reset between clock edges and confirm it takes effect at once.
    task automatic async_reset(input int idx);
        @(negedge clk);
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        check("rst_ccr",   idx, ccr, 3'b000);
        check("rst_empty", idx, {2'b00, stack_empty}, 3'b001);
        check("rst_full",  idx, {2'b00, stack_full},  3'b000);
        check("rst_err",   idx, {2'b00, stack_err},   3'b000);
        #1 rst = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t g;
        if (v.do_rst) async_reset(idx);
        @(negedge clk);
        alu_valid = v.valid; alu_func = v.func; alu_flags = v.flags;
        setc = v.setc; clrc = v.clrc; jmp_cond = v.jc; jmp_taken = v.jt;
        save = v.save; restore = v.restore;
        e.ccr = v.e_ccr; e.full = v.e_full; e.empty = v.e_empty; e.err = v.e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard vec %0d: got empty queue required one entry", idx);
        end else begin
            g = sb.pop_front();
            check("ccr",   idx, ccr, g.ccr);
            check("full",  idx, {2'b00, stack_full},  {2'b00, g.full});
            check("empty", idx, {2'b00, stack_empty}, {2'b00, g.empty});
            check("err",   idx, {2'b00, stack_err},   {2'b00, g.err});
        end
    endtask

    initial begin
        //              rst  v  func    flags      sc cc jc     jt sv rs  ccr    f  e  err
        vecs[0]  = mk(1'b0,1,F_ADD, 16'h0001, 0,0,2'b00,0,0,0, 3'b001,0,1,0);
        vecs[1]  = mk(1'b0,1,F_MOV1,16'h0006, 0,0,2'b00,0,0,0, 3'b001,0,1,0);
        vecs[2]  = mk(1'b0,1,F_ADD, 16'h0007, 0,0,2'b00,0,0,0, 3'b111,0,1,0);
        vecs[3]  = mk(1'b0,1,F_OR,  16'h0000, 0,0,2'b00,0,0,0, 3'b100,0,1,0);
        vecs[4]  = mk(1'b0,0,F_NOP, 16'h0000, 0,0,2'b11,1,0,0, 3'b000,0,1,0);
        vecs[5]  = mk(1'b0,1,F_ADD, 16'h0001, 0,0,2'b00,0,0,0, 3'b001,0,1,0);
        vecs[6]  = mk(1'b0,1,F_SUB, 16'h0001, 0,0,2'b01,1,0,0, 3'b001,0,1,0);
        vecs[7]  = mk(1'b0,0,F_NOP, 16'h0000, 0,0,2'b01,1,0,0, 3'b000,0,1,0);
        vecs[8]  = mk(1'b0,0,F_NOP, 16'h0000, 1,0,2'b00,0,0,0, 3'b100,0,1,0);
        vecs[9]  = mk(1'b0,0,F_NOP, 16'h0000, 1,1,2'b00,0,0,0, 3'b100,0,1,0);
        vecs[10] = mk(1'b0,0,F_NOP, 16'h0000, 0,1,2'b00,0,0,0, 3'b000,0,1,0);
        vecs[11] = mk(1'b0,1,F_NOT, 16'h0007, 1,0,2'b00,0,0,0, 3'b111,0,1,0);
        vecs[12] = mk(1'b0,1,F_AND, 16'h0000, 0,0,2'b10,1,0,0, 3'b100,0,1,0);
        vecs[13] = mk(1'b0,1,F_UNU, 16'h0007, 0,0,2'b00,0,0,0, 3'b100,0,1,0);
        vecs[14] = mk(1'b0,0,F_ADD, 16'h0003, 0,0,2'b00,0,0,0, 3'b100,0,1,0);
        vecs[15] = mk(1'b0,1,F_ADD, 16'h0005, 0,0,2'b00,0,0,0, 3'b101,0,1,0);
        // Pushes of 101, 010, 110, 001 while the CCR keeps updating.
        vecs[16] = mk(1'b0,1,F_ADD, 16'h0002, 0,0,2'b00,0,1,0, 3'b010,0,0,0);
        vecs[17] = mk(1'b0,1,F_ADD, 16'h0006, 0,0,2'b00,0,1,0, 3'b110,0,0,0);
        vecs[18] = mk(1'b0,1,F_ADD, 16'h0001, 0,0,2'b00,0,1,0, 3'b001,0,0,0);
        vecs[19] = mk(1'b0,0,F_NOP, 16'h0000, 0,0,2'b00,0,1,0, 3'b001,1,0,0);
        vecs[20] = mk(1'b0,1,F_ADD, 16'h0007, 0,0,2'b00,0,1,0, 3'b111,1,0,1);
        // Pops override the ALU update.
        vecs[21] = mk(1'b0,1,F_ADD, 16'h0000, 0,0,2'b00,0,0,1, 3'b001,0,0,1);
        vecs[22] = mk(1'b0,0,F_NOP, 16'h0000, 0,0,2'b00,0,0,1, 3'b110,0,0,1);
        vecs[23] = mk(1'b0,0,F_NOP, 16'h0000, 0,0,2'b00,0,0,1, 3'b010,0,0,1);
        vecs[24] = mk(1'b0,0,F_NOP, 16'h0000, 0,0,2'b00,0,0,1, 3'b101,0,1,1);
        vecs[25] = mk(1'b0,1,F_ADD, 16'h0003, 0,0,2'b00,0,1,0, 3'b011,0,0,1);
        vecs[26] = mk(1'b0,0,F_NOP, 16'h0000, 0,0,2'b00,0,1,0, 3'b011,0,0,1);
        // Reset with two entries stacked, then underflow with INC.
        vecs[27] = mk(1'b1,1,F_INC, 16'h0002, 0,0,2'b00,0,0,1, 3'b010,0,1,1);
        // Reset, then save+restore conflict: neither executes.
        vecs[28] = mk(1'b1,1,F_ADD, 16'h0004, 0,0,2'b00,0,1,1, 3'b100,0,1,1);
        vecs[29] = mk(1'b0,1,F_ADD, 16'h0002, 0,0,2'b00,0,0,1, 3'b010,0,1,1);
        vecs[30] = mk(1'b0,0,F_NOP, 16'h0000, 1,0,2'b11,1,0,0, 3'b110,0,1,1);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ccr",   -1, ccr, 3'b000);
        check("reset_empty", -1, {2'b00, stack_empty}, 3'b001);
        check("reset_full",  -1, {2'b00, stack_full},  3'b000);
        check("reset_err",   -1, {2'b00, stack_err},   3'b000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            apply(vecs[i], i);
        end

        @(negedge clk);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
